// File: rtl/mack_bus_ctrl.sv
// mack_bus_ctrl - bus-cycle controller for the Mackerel 68000 board.
//
// Decodes each AS-qualified CPU cycle into ROM, RAM, MFP, interrupt
// acknowledge or unmapped, inserts per-region wait states and returns a
// registered DTACK, VPA or BERR to the CPU. Also owns the boot overlay that
// maps every non-IACK access to ROM until BOOT_CYCLES bus cycles completed.
//
// Ports:
//   CLK       in   CPU clock
//   RST       in   synchronous reset, active-low
//   ADDR[8:0] in   CPU address bits A23..A15
//   FC[2:0]   in   CPU function code
//   AS        in   address strobe, active-low
//   DTACK_IN  in   DTACK from the MFP, active-low (same clock domain)
//   ROMEN     out  ROM chip enable, active-low
//   RAMEN     out  RAM chip enable, active-low
//   MFPEN     out  MFP chip select, active-low
//   IACKEN    out  interrupt acknowledge to MFP, active-low
//   DTACK     out  DTACK to CPU, active-low, registered
//   VPA       out  autovector request to CPU, active-low, registered
//   BERR      out  bus error to CPU, active-low, registered
//   BOOT      out  1 = boot overlay finished, registered
//
// Build option: define BUS_ERROR_EN to add the unmapped/MFP timeout that
// drives BERR. Without it BERR is tied high and unmapped cycles hang.
//
// State    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no cycle in progress, waiting for AS low
// WAIT     | ROM/RAM wait states counting down
// MFPWAIT  | waiting for DTACK_IN from the MFP
// IACKWAIT | interrupt acknowledge, waiting for DTACK_IN or autovector
// ACK      | chosen strobe held low until AS returns high
// TERM     | unmapped access, waiting for AS high (or bus-error timeout)

module mack_bus_ctrl #(
  parameter int unsigned ROM_WS      = 2,
  parameter int unsigned RAM_WS      = 0,
  parameter int unsigned BOOT_CYCLES = 8,
  parameter int unsigned AVEC_WAIT   = 8,
  parameter int unsigned BERR_CYCLES = 64
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [8:0] ADDR,
  input  logic [2:0] FC,
  input  logic       AS,
  input  logic       DTACK_IN,
  output logic       ROMEN,
  output logic       RAMEN,
  output logic       MFPEN,
  output logic       IACKEN,
  output logic       DTACK,
  output logic       VPA,
  output logic       BERR,
  output logic       BOOT
);

  // One shared down-counter serves wait states, autovector wait and the
  // bus-error timeout, so it is sized for the largest of them.
  localparam int unsigned MAX_A   = (AVEC_WAIT > 15) ? AVEC_WAIT : 15;
  localparam int unsigned MAX_CNT = (BERR_CYCLES > MAX_A) ? BERR_CYCLES : MAX_A;
  localparam int          CW      = $clog2(MAX_CNT + 1);
  localparam int          BW      = (BOOT_CYCLES < 2) ? 1 : $clog2(BOOT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_MFPWAIT, S_IACKWAIT, S_ACK, S_TERM
  } state_t;

  typedef enum logic [2:0] {
    R_ROM, R_RAM, R_MFP, R_IACK, R_UNM
  } region_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dtack_q, dtack_d;
  logic          vpa_q, vpa_d;
  logic          berr_q, berr_d;
  logic [BW-1:0] boot_cnt_q;
  logic          boot_q;
  logic          as_prev_q;
  region_t       region;
  logic          unused_addr;

  // A23/A22 are not decoded; the map mirrors every 4 MB.
  assign unused_addr = ^ADDR[8:7];

  always_comb begin
    region = R_UNM;
    if (FC == 3'b111) begin
      region = R_IACK;
    end else if (!boot_q) begin
      region = R_ROM;
    end else begin
      case (ADDR[6:4])
        3'b111:  region = R_ROM;
        3'b110:  region = R_MFP;
        3'b000:  region = R_RAM;
        default: region = R_UNM;
      endcase
    end
  end

  assign ROMEN  = !(!AS && region == R_ROM);
  assign RAMEN  = !(!AS && region == R_RAM);
  assign MFPEN  = !(region == R_MFP);
  assign IACKEN = !(!AS && FC == 3'b111);

  // Boot overlay: count AS rising edges; BOOT rises on the edge the count
  // completes, so the final boot cycle itself still decoded as ROM.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      boot_cnt_q <= '0;
      boot_q     <= 1'b0;
      as_prev_q  <= 1'b1;
    end else begin
      as_prev_q <= AS;
      if (!as_prev_q && AS && !boot_q) begin
        boot_cnt_q <= boot_cnt_q + 1'b1;
        if (boot_cnt_q == BW'(BOOT_CYCLES - 1)) begin
          boot_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dtack_q <= 1'b1;
      vpa_q   <= 1'b1;
      berr_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dtack_q <= dtack_d;
      vpa_q   <= vpa_d;
      berr_q  <= berr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dtack_d = dtack_q;
    vpa_d   = vpa_q;
    berr_d  = berr_q;
    case (state_q)
      S_IDLE: begin
        if (!AS) begin
          case (region)
            R_ROM: begin
              cnt_d   = CW'(ROM_WS);
              state_d = S_WAIT;
            end
            R_RAM: begin
              cnt_d   = CW'(RAM_WS);
              state_d = S_WAIT;
            end
            R_MFP: begin
`ifdef BUS_ERROR_EN
              cnt_d   = CW'(BERR_CYCLES);
`endif
              state_d = S_MFPWAIT;
            end
            R_IACK: begin
              cnt_d   = CW'(AVEC_WAIT);
              state_d = S_IACKWAIT;
            end
            default: begin
`ifdef BUS_ERROR_EN
              cnt_d   = CW'(BERR_CYCLES);
`endif
              state_d = S_TERM;
            end
          endcase
        end
      end
      S_WAIT: begin
        if (AS) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          dtack_d = 1'b0;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_MFPWAIT: begin
        if (AS) begin
          state_d = S_IDLE;
        end else if (!DTACK_IN) begin
          dtack_d = 1'b0;
          state_d = S_ACK;
        end
`ifdef BUS_ERROR_EN
        else if (cnt_q == '0) begin
          berr_d  = 1'b0;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`endif
      end
      S_IACKWAIT: begin
        // DTACK_IN is tested before the counter so a vectored response
        // wins over the autovector fallback on the same edge.
        if (AS) begin
          state_d = S_IDLE;
        end else if (!DTACK_IN) begin
          dtack_d = 1'b0;
          state_d = S_ACK;
        end else if (cnt_q == '0) begin
          vpa_d   = 1'b0;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_ACK: begin
        if (AS) begin
          dtack_d = 1'b1;
          vpa_d   = 1'b1;
          berr_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_TERM: begin
        if (AS) begin
          state_d = S_IDLE;
        end
`ifdef BUS_ERROR_EN
        else if (cnt_q == '0) begin
          berr_d  = 1'b0;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign DTACK = dtack_q;
  assign VPA   = vpa_q;
  assign BOOT  = boot_q;
`ifdef BUS_ERROR_EN
  assign BERR  = berr_q;
`else
  assign BERR  = 1'b1;
  logic unused_berr;
  assign unused_berr = berr_q;
`endif

endmodule

// File: tb/tb_mack_bus_ctrl.sv
// Testbench for mack_bus_ctrl: table of directed bus cycles, a mid-cycle
// reset sequence and randomized cycles checked against a cycle-level model.
module tb_mack_bus_ctrl;

  localparam int ROM_WS      = 2;
  localparam int RAM_WS      = 0;
  localparam int BOOT_CYCLES = 8;
  localparam int AVEC_WAIT   = 8;
  localparam int BERR_CYCLES = 64;

  // strobe kinds
  localparam int K_NONE = 0;
  localparam int K_DT   = 1;
  localparam int K_VPA  = 2;
  localparam int K_BERR = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [8:0] addr = '0;
  logic [2:0] fc = 3'd5;
  logic       as_n = 1'b1;
  logic       dtack_in = 1'b1;
  logic       romen, ramen, mfpen, iacken, dtack, vpa, berr, boot;

  int checks = 0;
  int failures = 0;
  int done_cycles = 0;

  mack_bus_ctrl #(
    .ROM_WS(ROM_WS), .RAM_WS(RAM_WS), .BOOT_CYCLES(BOOT_CYCLES),
    .AVEC_WAIT(AVEC_WAIT), .BERR_CYCLES(BERR_CYCLES)
  ) dut (
    .CLK(clk), .RST(rst), .ADDR(addr), .FC(fc), .AS(as_n), .DTACK_IN(dtack_in),
    .ROMEN(romen), .RAMEN(ramen), .MFPEN(mfpen), .IACKEN(iacken),
    .DTACK(dtack), .VPA(vpa), .BERR(berr), .BOOT(boot)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] a;
    logic [2:0] f;
    int         d;     // edge at which DTACK_IN is first sampled low, 0 = never
    int         hold;  // last edge at which AS is sampled low
    logic [3:0] en;    // {ROMEN,RAMEN,MFPEN,IACKEN} while AS low
    int         kind;
    int         e_at;  // edge the strobe goes low
    logic       boot;  // BOOT after the cycle
  } vec_t;

  localparam int NV = 17;
  vec_t vt [0:NV-1];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: decides region and response from the memory map rules.
  task automatic model(input logic [8:0] a, input logic [2:0] f, input int d,
                       output logic [3:0] en, output int kind, output int e_at);
    bit    booted;
    string rgn;
    booted = (done_cycles >= BOOT_CYCLES);
    if (f == 3'd7)            rgn = "IACK";
    else if (!booted)         rgn = "ROM";
    else if (a[6:4] == 3'd7)  rgn = "ROM";
    else if (a[6:4] == 3'd6)  rgn = "MFP";
    else if (a[6:4] == 3'd0)  rgn = "RAM";
    else                      rgn = "UNM";
    en   = {rgn != "ROM", rgn != "RAM", rgn != "MFP", rgn != "IACK"};
    kind = K_NONE;
    e_at = 0;
    if (rgn == "ROM") begin
      kind = K_DT; e_at = 1 + ROM_WS;
    end else if (rgn == "RAM") begin
      kind = K_DT; e_at = 1 + RAM_WS;
    end else if (rgn == "IACK") begin
      if (d != 0 && d <= 1 + AVEC_WAIT) begin kind = K_DT; e_at = d; end
      else begin kind = K_VPA; e_at = 1 + AVEC_WAIT; end
    end else if (rgn == "MFP") begin
`ifdef BUS_ERROR_EN
      if (d != 0 && d <= 1 + BERR_CYCLES) begin kind = K_DT; e_at = d; end
      else begin kind = K_BERR; e_at = 1 + BERR_CYCLES; end
`else
      if (d != 0) begin kind = K_DT; e_at = d; end
`endif
    end else begin
`ifdef BUS_ERROR_EN
      kind = K_BERR; e_at = 1 + BERR_CYCLES;
`endif
    end
  endtask

  // One bus cycle: AS sampled low at edges 0..hold, high at hold+1.
  task automatic run_cycle(input string tag, input logic [8:0] a, input logic [2:0] f,
                           input int d, input int hold, input logic [3:0] exp_en,
                           input int kind, input int e_at, input logic exp_boot);
    logic [2:0] exp_s;
    @(negedge clk);
    addr = a; fc = f; dtack_in = 1'b1; as_n = 1'b0;
    #1 check({tag, ":en"}, {4'b0, romen, ramen, mfpen, iacken}, {4'b0, exp_en});
    for (int e = 0; e <= hold + 1; e++) begin
      @(posedge clk);
      #1;
      exp_s = 3'b111;
      if (kind != K_NONE && e >= e_at && e <= hold) exp_s[3 - kind] = 1'b0;
      check($sformatf("%s:strobe@%0d", tag, e), {5'b0, dtack, vpa, berr}, {5'b0, exp_s});
      if (e <= hold) begin
        @(negedge clk);
        if (d != 0 && e + 1 >= d) dtack_in = 1'b0;
        if (e == hold) as_n = 1'b1;
      end
    end
    check({tag, ":boot"}, {7'b0, boot}, {7'b0, exp_boot});
    dtack_in = 1'b1;
    if (done_cycles < BOOT_CYCLES) done_cycles++;
  endtask

  initial begin
    logic [3:0] m_en;
    int         m_kind, m_eat, d, hold;
    logic [8:0] a;
    logic [2:0] f;
    logic [2:0] fcs [0:4];

    for (int i = 0; i < 8; i++)
      vt[i] = '{9'h000, 3'd5, 0, 4, 4'b0111, K_DT, 3, (i == 7)};
    vt[8]  = '{9'h000, 3'd5, 0, 2, 4'b1011, K_DT, 1, 1'b1};
    vt[9]  = '{9'h070, 3'd5, 0, 5, 4'b0111, K_DT, 3, 1'b1};
    vt[10] = '{9'h060, 3'd5, 5, 7, 4'b1101, K_DT, 5, 1'b1};
    vt[11] = '{9'h07F, 3'd7, 0, 11, 4'b1110, K_VPA, 9, 1'b1};
    vt[12] = '{9'h07F, 3'd7, 3, 5, 4'b1110, K_DT, 3, 1'b1};
`ifdef BUS_ERROR_EN
    vt[13] = '{9'h010, 3'd5, 0, 66, 4'b1111, K_BERR, 65, 1'b1};
`else
    vt[13] = '{9'h010, 3'd5, 0, 10, 4'b1111, K_NONE, 0, 1'b1};
`endif
    vt[14] = '{9'h070, 3'd6, 0, 1, 4'b0111, K_NONE, 0, 1'b1};
    vt[15] = '{9'h07F, 3'd7, 9, 10, 4'b1110, K_DT, 9, 1'b1};
    vt[16] = '{9'h180, 3'd5, 0, 1, 4'b1011, K_DT, 1, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("reset:strobes", {5'b0, dtack, vpa, berr}, 8'h07);
    check("reset:boot", {7'b0, boot}, 8'h00);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++)
      run_cycle($sformatf("vec%0d", i), vt[i].a, vt[i].f, vt[i].d, vt[i].hold,
                vt[i].en, vt[i].kind, vt[i].e_at, vt[i].boot);

    // MFP select does not depend on AS
    @(negedge clk);
    addr = 9'h060; fc = 3'd5; as_n = 1'b1;
    #1 check("mfpen_as_high", {6'b0, mfpen, romen}, 8'h01);

    // Reset while a ROM cycle sits in WAIT
    @(negedge clk);
    addr = 9'h070; fc = 3'd5; as_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid:strobes", {5'b0, dtack, vpa, berr}, 8'h07);
    check("rst_mid:boot", {7'b0, boot}, 8'h00);
    @(posedge clk);
    #1 check("rst_mid:dtack_late", {7'b0, dtack}, 8'h01);
    @(negedge clk);
    rst = 1'b1; as_n = 1'b1;
    @(posedge clk);
    #1 check("rst_mid:idle", {5'b0, dtack, vpa, berr}, 8'h07);
    done_cycles = 0;
    run_cycle("post_rst", 9'h000, 3'd5, 0, 4, 4'b0111, K_DT, 1 + ROM_WS, 1'b0);

    // Randomized cycles against the model (boot overlay restarts from 1 done)
    fcs[0] = 3'd1; fcs[1] = 3'd2; fcs[2] = 3'd5; fcs[3] = 3'd6; fcs[4] = 3'd7;
    for (int n = 0; n < 40; n++) begin
      a    = 9'($urandom_range(0, 511));
      f    = fcs[$urandom_range(0, 4)];
      d    = $urandom_range(0, 12);
      hold = $urandom_range(0, 14);
      model(a, f, d, m_en, m_kind, m_eat);
      run_cycle($sformatf("rnd%0d", n), a, f, d, hold, m_en, m_kind, m_eat,
                (done_cycles + 1 >= BOOT_CYCLES));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
